// File: rtl/prog_loader_if.sv
// Byte-stream and fake_ram write-port bundle for prog_loader.
// The slave modport is the loader side; the master modport is the byte source / RAM observer.
interface prog_loader_if #(
    parameter int ADDR_W = 16
);
    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
    // byte_valid may be raised or dropped at any time and the byte is held by the
    // source until it transfers.
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_dataI;

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output ram_we,
        output ram_addr,
        output ram_dataI
    );

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  ram_we,
        input  ram_addr,
        input  ram_dataI
    );
endinterface

// File: rtl/prog_loader.sv
// Loads little-endian byte pairs into fake_ram as 16-bit words while holding the CPU in reset.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] word_count,
    prog_loader_if.slave bus,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LO    = 3'd1,
        HI    = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
`ifdef PROG_LOADER_CHECKSUM_EN
        ,CHK  = 3'd5
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx_q, idx_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [15:0]       data_q, data_n;
    logic [15:0]       wc_q, wc_n;
    logic              err_q, err_n;
    logic [ADDR_W-1:0] idx_inc;
    logic              last;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_n;
`endif

    assign idx_inc = idx_q + 1'b1;
    assign last    = (32'(idx_inc) == 32'(wc_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx_q  <= '0;
            addr_q <= BASE;
            data_q <= '0;
            wc_q   <= '0;
            err_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            state  <= state_n;
            idx_q  <= idx_n;
            addr_q <= addr_n;
            data_q <= data_n;
            wc_q   <= wc_n;
            err_q  <= err_n;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx_q;
        addr_n  = addr_q;
        data_n  = data_q;
        wc_n    = wc_q;
        err_n   = err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_n  = csum_q;
`endif
        case (state)
            // start is only honoured between sessions; a stray pulse while busy is dropped
            IDLE, DONE: begin
                if (start) begin
                    err_n  = 1'b0;
                    idx_n  = '0;
                    addr_n = BASE;
                    wc_n   = word_count;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_n = '0;
`endif
                    if (word_count == 16'd0) begin
                        state_n = DONE;
                    end else if (int'(word_count) > DEPTH) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = LO;
                    end
                end
            end
            LO: begin
                if (bus.byte_valid) begin
                    data_n[7:0] = bus.byte_in;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_n = csum_q ^ bus.byte_in;
`endif
                    state_n = HI;
                end
            end
            HI: begin
                if (bus.byte_valid) begin
                    data_n[15:8] = bus.byte_in;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_n = csum_q ^ bus.byte_in;
`endif
                    state_n = WRITE;
                end
            end
            WRITE: begin
                idx_n  = idx_inc;
                addr_n = addr_q + 1'b1;
                if (last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_n = CHK;
`else
                    state_n = DONE;
`endif
                end else begin
                    state_n = LO;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
                if (bus.byte_valid) begin
                    if (bus.byte_in == csum_q) begin
                        state_n = DONE;
                    end else begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // All status outputs decode from the state so they follow it on the same edge
    assign bus.ram_we    = (state == WRITE);
    assign bus.ram_addr  = addr_q;
    assign bus.ram_dataI = data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign bus.byte_ready = (state == LO) || (state == HI) || (state == CHK);
    assign busy           = (state == LO) || (state == HI) || (state == WRITE) || (state == CHK);
`else
    assign bus.byte_ready = (state == LO) || (state == HI);
    assign busy           = (state == LO) || (state == HI) || (state == WRITE);
`endif
    assign done      = (state == DONE);
    assign cpu_reset = (state != DONE);
    assign err       = err_q;
    assign dbg_state = state;

endmodule
